// File: rtl/test_prj_mj2_sram_cell_arb.sv
// Two-port round-robin arbiter in front of a single-port SRAM cell.
// Grants are combinational; read data returns one cycle after the grant.
module test_prj_mj2_sram_cell_arb #(
    parameter int BW_INDEX = 15,
    parameter int BW_DATA  = 32
) (
    input  logic                      clk,
    input  logic                      rstnn,
    input  logic                      p0_req,
    input  logic [BW_INDEX-1:0]       p0_index,
    input  logic                      p0_wenable,
    input  logic [BW_DATA/8-1:0]      p0_wbyte,
    input  logic [BW_DATA-1:0]        p0_wdata,
    output logic                      p0_gnt,
    output logic                      p0_rvalid,
    output logic [BW_DATA-1:0]        p0_rdata,
    input  logic                      p1_req,
    input  logic [BW_INDEX-1:0]       p1_index,
    input  logic                      p1_wenable,
    input  logic [BW_DATA/8-1:0]      p1_wbyte,
    input  logic [BW_DATA-1:0]        p1_wdata,
    output logic                      p1_gnt,
    output logic                      p1_rvalid,
    output logic [BW_DATA-1:0]        p1_rdata,
    output logic                      cell_enable,
    output logic                      cell_wenable,
    output logic                      cell_renable,
    output logic [BW_INDEX-1:0]       cell_index,
    output logic [BW_DATA/8-1:0]      cell_wbyte,
    output logic [BW_DATA-1:0]        cell_wdata,
    input  logic [BW_DATA-1:0]        cell_rdata
);

    localparam int BW_BYTE_WEN = BW_DATA / 8;

    // last_gnt_q: 1 means p1 won last, so p0 wins the next conflict
    logic last_gnt_q, last_gnt_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic granted_wen;

    // Round-robin grant; held low while reset is asserted
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rstnn) begin
            p0_gnt = p0_req & (~p1_req | last_gnt_q);
            p1_gnt = p1_req & (~p0_req | ~last_gnt_q);
        end
    end

    // Steer the granted port onto the cell; zeros when idle
    always_comb begin
        cell_index  = '0;
        cell_wbyte  = '0;
        cell_wdata  = '0;
        granted_wen = 1'b0;
        if (p0_gnt) begin
            cell_index  = p0_index;
            cell_wbyte  = p0_wbyte;
            cell_wdata  = p0_wdata;
            granted_wen = p0_wenable;
        end else if (p1_gnt) begin
            cell_index  = p1_index;
            cell_wbyte  = p1_wbyte;
            cell_wdata  = p1_wdata;
            granted_wen = p1_wenable;
        end
        cell_enable  = p0_gnt | p1_gnt;
        cell_wenable = cell_enable & granted_wen;
        cell_renable = cell_enable & ~granted_wen;
    end

    // Next-state for arbitration history and the pending read slot
    always_comb begin
        last_gnt_d = last_gnt_q;
        rd_owner_d = rd_owner_q;
        rd_pend_d  = cell_renable;
        if (p0_gnt) begin
            last_gnt_d = 1'b0;
        end else if (p1_gnt) begin
            last_gnt_d = 1'b1;
        end
        if (cell_renable) begin
            rd_owner_d = p1_gnt;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            last_gnt_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Route returning read data to its owner only
    always_comb begin
        p0_rvalid = rd_pend_q & ~rd_owner_q;
        p1_rvalid = rd_pend_q & rd_owner_q;
        p0_rdata  = p0_rvalid ? cell_rdata : '0;
        p1_rdata  = p1_rvalid ? cell_rdata : '0;
    end

    logic unused_bw;
    assign unused_bw = (BW_BYTE_WEN == 0);

endmodule

// File: tb/tb_test_prj_mj2_sram_cell_arb.sv
// Directed bench for the SRAM cell arbiter with a behavioural cell.
// Stimulus changes 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_test_prj_mj2_sram_cell_arb;

    logic        clk;
    logic        rstnn;
    logic        p0_req, p0_wenable, p0_gnt, p0_rvalid;
    logic [14:0] p0_index;
    logic [3:0]  p0_wbyte;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_wenable, p1_gnt, p1_rvalid;
    logic [14:0] p1_index;
    logic [3:0]  p1_wbyte;
    logic [31:0] p1_wdata, p1_rdata;
    logic        cell_enable, cell_wenable, cell_renable;
    logic [14:0] cell_index;
    logic [3:0]  cell_wbyte;
    logic [31:0] cell_wdata, cell_rdata;

    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] mem [16];

    int n_cmp;
    int n_err;

    test_prj_mj2_sram_cell_arb #(.BW_INDEX(15), .BW_DATA(32)) dut (
        .clk(clk), .rstnn(rstnn),
        .p0_req(p0_req), .p0_index(p0_index), .p0_wenable(p0_wenable),
        .p0_wbyte(p0_wbyte), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_index(p1_index), .p1_wenable(p1_wenable),
        .p1_wbyte(p1_wbyte), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .cell_enable(cell_enable), .cell_wenable(cell_wenable),
        .cell_renable(cell_renable), .cell_index(cell_index),
        .cell_wbyte(cell_wbyte), .cell_wdata(cell_wdata),
        .cell_rdata(cell_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port cell with synchronous read and a backdoor loader
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (cell_enable && cell_wenable)
            for (int b = 0; b < 4; b++)
                if (cell_wbyte[b]) mem[cell_index[3:0]][b*8 +: 8] <= cell_wdata[b*8 +: 8];
        if (cell_enable && cell_renable) cell_rdata <= mem[cell_index[3:0]];
    end

    task automatic clr();
        p0_req = 0; p0_wenable = 0; p0_index = '0; p0_wbyte = '0; p0_wdata = '0;
        p1_req = 0; p1_wenable = 0; p1_index = '0; p1_wbyte = '0; p1_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] d);
        bd_we = 1; bd_idx = idx; bd_data = d;
        tick();
        bd_we = 0;
    endtask

    task automatic apply_reset();
        clr();
        rstnn = 0;
        tick();
        rstnn = 1;
    endtask

    task automatic test_reset();
        rstnn = 0;
        p0_req = 1; p1_req = 1; p0_index = 15'd5; p1_index = 15'd6;
        p0_wdata = 32'h1; p0_wbyte = 4'hF;
        #1;
        n_cmp++; if ({p0_gnt, p1_gnt} !== 2'b00) begin n_err++; $display("FAIL rst_gnt got %b exp 00", {p0_gnt, p1_gnt}); end
        n_cmp++; if ({cell_enable, cell_wenable, cell_renable, cell_index, cell_wbyte, cell_wdata} !== '0) begin n_err++; $display("FAIL rst_cell got %h exp 0", {cell_enable, cell_index, cell_wdata}); end
        n_cmp++; if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== '0) begin n_err++; $display("FAIL rst_rd got %b%b exp 00", p0_rvalid, p1_rvalid); end
        clr();
        preload(4'd5, 32'hDEADBEEF);
        preload(4'd0, 32'hC0DE0000);
        preload(4'd1, 32'h11111111);
        preload(4'd2, 32'h22222222);
        preload(4'd3, 32'hAABBCCDD);
        rstnn = 1;
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_index = 15'd5;
        #1;
        n_cmp++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_err++; $display("FAIL sr_gnt got %b exp 10", {p0_gnt, p1_gnt}); end
        n_cmp++; if ({cell_renable, cell_wenable, cell_index} !== {2'b10, 15'd5}) begin n_err++; $display("FAIL sr_cell got %b%b %0d exp 10 5", cell_renable, cell_wenable, cell_index); end
        tick();
        clr();
        n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b10) begin n_err++; $display("FAIL sr_rvalid got %b exp 10", {p0_rvalid, p1_rvalid}); end
        n_cmp++; if (p0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sr_rdata got %h exp deadbeef", p0_rdata); end
        n_cmp++; if (p1_rdata !== 32'h0) begin n_err++; $display("FAIL sr_p1rdata got %h exp 0", p1_rdata); end
        tick();
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_err++; $display("FAIL sr_pulse got %b exp 0", p0_rvalid); end
    endtask

    task automatic test_round_robin();
        logic e0;
        apply_reset();
        p0_req = 1; p0_index = 15'd1;
        p1_req = 1; p1_index = 15'd2;
        for (int i = 0; i < 6; i++) begin
            e0 = (i % 2 == 0);
            #1;
            n_cmp++; if ({p0_gnt, p1_gnt} !== {e0, ~e0}) begin n_err++; $display("FAIL rr_gnt%0d got %b exp %b", i, {p0_gnt, p1_gnt}, {e0, ~e0}); end
            tick();
            n_cmp++; if ({p0_rvalid, p1_rvalid} !== {e0, ~e0}) begin n_err++; $display("FAIL rr_rv%0d got %b exp %b", i, {p0_rvalid, p1_rvalid}, {e0, ~e0}); end
            n_cmp++; if ((p0_rdata | p1_rdata) !== (e0 ? 32'h11111111 : 32'h22222222)) begin n_err++; $display("FAIL rr_rd%0d got %h/%h", i, p0_rdata, p1_rdata); end
        end
        clr();
        tick();
    endtask

    task automatic test_partial_write();
        p1_req = 1; p1_wenable = 1; p1_index = 15'd3;
        p1_wbyte = 4'b0011; p1_wdata = 32'h12345678;
        #1;
        n_cmp++; if ({p0_gnt, p1_gnt, cell_wenable, cell_renable} !== 4'b0110) begin n_err++; $display("FAIL pw_ctl got %b exp 0110", {p0_gnt, p1_gnt, cell_wenable, cell_renable}); end
        n_cmp++; if ({cell_index, cell_wbyte, cell_wdata} !== {15'd3, 4'b0011, 32'h12345678}) begin n_err++; $display("FAIL pw_bus got %0d %b %h exp 3 0011 12345678", cell_index, cell_wbyte, cell_wdata); end
        tick();
        clr();
        n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_err++; $display("FAIL pw_norv got %b exp 00", {p0_rvalid, p1_rvalid}); end
        p0_req = 1; p0_index = 15'd3;
        tick();
        clr();
        n_cmp++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hAABB5678}) begin n_err++; $display("FAIL pw_rd got %b %h exp 1 aabb5678", p0_rvalid, p0_rdata); end
        tick();
    endtask

    task automatic test_zero_wbyte();
        p0_req = 1; p0_wenable = 1; p0_index = 15'd3;
        p0_wbyte = 4'b0000; p0_wdata = 32'hFFFFFFFF;
        #1;
        n_cmp++; if ({p0_gnt, cell_enable, cell_wenable} !== 3'b111) begin n_err++; $display("FAIL zw_gnt got %b exp 111", {p0_gnt, cell_enable, cell_wenable}); end
        tick();
        clr();
        p0_req = 1; p0_index = 15'd3;
        tick();
        clr();
        n_cmp++; if (p0_rdata !== 32'hAABB5678) begin n_err++; $display("FAIL zw_rd got %h exp aabb5678", p0_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        p0_req = 1; p0_index = 15'd5;
        #1;
        n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL mr_gnt got %b exp 1", p0_gnt); end
        rstnn = 0;
        #1;
        n_cmp++; if (p0_gnt !== 1'b0) begin n_err++; $display("FAIL mr_gntrst got %b exp 0", p0_gnt); end
        tick();
        clr();
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_err++; $display("FAIL mr_rv1 got %b exp 0", p0_rvalid); end
        rstnn = 1;
        tick();
        n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_err++; $display("FAIL mr_stale1 got %b exp 00", {p0_rvalid, p1_rvalid}); end
        p0_req = 1; p0_index = 15'd5;
        tick();
        clr();
        n_cmp++; if (p0_rvalid !== 1'b1) begin n_err++; $display("FAIL mr_pend got %b exp 1", p0_rvalid); end
        rstnn = 0;
        #1;
        n_cmp++; if ({p0_rvalid, p0_rdata} !== 33'h0) begin n_err++; $display("FAIL mr_kill got %b %h exp 0", p0_rvalid, p0_rdata); end
        rstnn = 1;
        tick();
        n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_err++; $display("FAIL mr_stale2 got %b exp 00", {p0_rvalid, p1_rvalid}); end
        p0_req = 1; p1_req = 1;
        #1;
        n_cmp++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_err++; $display("FAIL mr_first got %b exp 10", {p0_gnt, p1_gnt}); end
        tick();
        clr();
        tick();
    endtask

    task automatic test_idle();
        p0_index = 15'd7; p0_wdata = 32'hCAFEF00D; p0_wbyte = 4'hF; p0_wenable = 1;
        p1_index = 15'd9; p1_wdata = 32'h0BADF00D; p1_wbyte = 4'hF;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if ({p0_gnt, p1_gnt, cell_enable, cell_wenable, cell_renable, cell_index, cell_wbyte, cell_wdata} !== '0) begin n_err++; $display("FAIL idle%0d got en=%b idx=%0d wd=%h", i, cell_enable, cell_index, cell_wdata); end
            tick();
        end
        clr();
        p0_req = 1; p1_req = 1;
        #1;
        n_cmp++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_err++; $display("FAIL idle_hist got %b exp 01", {p0_gnt, p1_gnt}); end
        tick();
        clr();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hC0DE0000; exp_d[1] = 32'h11111111;
        exp_d[2] = 32'h22222222; exp_d[3] = 32'hAABB5678;
        for (int i = 0; i < 4; i++) begin
            p0_req = 1; p0_index = 15'(i);
            #1;
            n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt%0d got %b exp 1", i, p0_gnt); end
            if (i > 0) begin
                n_cmp++; if ({p0_rvalid, p0_rdata} !== {1'b1, exp_d[i-1]}) begin n_err++; $display("FAIL b2b_rd%0d got %b %h exp 1 %h", i-1, p0_rvalid, p0_rdata, exp_d[i-1]); end
            end
            tick();
        end
        clr();
        n_cmp++; if ({p0_rvalid, p0_rdata} !== {1'b1, exp_d[3]}) begin n_err++; $display("FAIL b2b_rd3 got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp_d[3]); end
        tick();
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", p0_rvalid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bd_we = 0; bd_idx = '0; bd_data = '0;
        cell_rdata = '0;
        clr();
        rstnn = 0;
        #2;
        test_reset();
        test_single_read();
        test_round_robin();
        test_partial_write();
        test_zero_wbyte();
        test_reset_mid_read();
        test_idle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
